// File: rtl/ec_pkg.sv
// Shared constants and coder-state type for the entropy-coder range/renormalization stages.
// Every stage that imports this package uses the same reset state and byte-extraction threshold.
package ec_pkg;

    localparam int EC_RANGE_WIDTH = 16;
    localparam int EC_LOW_WIDTH   = 24;
    localparam int EC_D_SIZE      = 5;

    localparam logic [EC_RANGE_WIDTH-1:0] RANGE_INIT = 16'h8000;

    localparam int BYTE_THRESH = 9;
    localparam int BYTE_BITS   = 8;
    localparam int BOOL_OFFSET = 4;

    typedef struct packed {
        logic [EC_RANGE_WIDTH-1:0] range;
        logic [EC_LOW_WIDTH-1:0]   low;
        logic [EC_D_SIZE-1:0]      s;
    } coder_state_t;

    function automatic coder_state_t coder_reset_state();
        coder_state_t st;
        st.range = RANGE_INIT;
        st.low   = '0;
        st.s     = '0;
        return st;
    endfunction

endpackage

// File: rtl/leading_zero.sv
// Leading-zero count of a RANGE_WIDTH vector; an all-zero input returns RANGE_WIDTH.
// The caller is responsible for any special handling of the zero case.
module leading_zero #(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5
) (
    input  logic [RANGE_WIDTH-1:0] value,
    output logic [D_SIZE-1:0]      count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count = D_SIZE'(RANGE_WIDTH);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (value[i]) count = D_SIZE'(RANGE_WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/stage_2_pipe.sv
// Registered range update plus one-round renormalization with byte extraction.
// Owns range/low/s and closes the feedback loop in one cycle, so one symbol per clock.
module stage_2_pipe
    import ec_pkg::*;
#(
    parameter int RANGE_WIDTH  = EC_RANGE_WIDTH,
    parameter int LOW_WIDTH    = EC_LOW_WIDTH,
    parameter int D_SIZE       = EC_D_SIZE,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_flush,
    input  logic [RANGE_WIDTH-1:0]         UU,
    input  logic [RANGE_WIDTH-1:0]         VV,
    input  logic [RANGE_WIDTH-1:0]         lut_u,
    input  logic [RANGE_WIDTH-1:0]         lut_v,
    input  logic                           COMP_mux_1,
    input  logic                           bool,
    input  logic [SYMBOL_WIDTH-1:0]        symbol,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_byte_valid,
    output logic [LOW_WIDTH-RANGE_WIDTH-1:0] out_byte,
    output logic                           out_flush,
    output logic [LOW_WIDTH-1:0]           out_low,
    output logic [D_SIZE-1:0]              out_s,
    output logic [RANGE_WIDTH-1:0]         out_range,
    output logic                           err_range_zero
);

    localparam int UW = RANGE_WIDTH + 1;
    localparam int PW = 2 * RANGE_WIDTH;
    localparam int BW = LOW_WIDTH - RANGE_WIDTH;

    coder_state_t st_q;
    coder_state_t st_n;

    logic [RANGE_WIDTH-1:0] range_q;
    logic [LOW_WIDTH-1:0]   low_q;
    logic [D_SIZE-1:0]      s_q;

    assign range_q = st_q.range;
    assign low_q   = st_q.low;
    assign s_q     = st_q.s;

    logic [RANGE_WIDTH-1:0] rr;
    logic [PW-1:0]          rr_uu;
    logic [PW-1:0]          rr_vv;
    logic [UW-1:0]          u;
    logic [UW-1:0]          v;
    logic [UW-1:0]          vb;

    assign rr    = range_q >> 8;
    assign rr_uu = PW'(rr) * PW'(UU);
    assign rr_vv = PW'(rr) * PW'(VV);
    assign u     = UW'(rr_uu >> 1) + UW'(lut_u);
    assign v     = UW'(rr_vv >> 1) + UW'(lut_v);
    assign vb    = UW'(rr_vv >> 1) + UW'(BOOL_OFFSET);

    logic [RANGE_WIDTH-1:0] range_pre;
    logic [LOW_WIDTH-1:0]   low_pre;

    // Interval selection; low only moves when the symbol sits above the lower bound.
    always_comb begin
        range_pre = '0;
        low_pre   = low_q;
        if (bool) begin
            if (symbol[0]) begin
                low_pre   = low_q + (LOW_WIDTH'(range_q) - LOW_WIDTH'(vb));
                range_pre = RANGE_WIDTH'(vb);
            end else begin
                range_pre = RANGE_WIDTH'(UW'(range_q) - vb);
            end
        end else if (COMP_mux_1) begin
            low_pre   = low_q + (LOW_WIDTH'(range_q) - LOW_WIDTH'(u));
            range_pre = RANGE_WIDTH'(u - v);
        end else begin
            range_pre = RANGE_WIDTH'(UW'(range_q) - v);
        end
    end

    logic [D_SIZE-1:0] lz;

    leading_zero #(
        .RANGE_WIDTH (RANGE_WIDTH),
        .D_SIZE      (D_SIZE)
    ) u_lz (
        .value (range_pre),
        .count (lz)
    );

    logic                   range_zero;
    logic [D_SIZE-1:0]      d;
    logic [D_SIZE-1:0]      s1;
    logic [RANGE_WIDTH-1:0] range_n;
    logic [LOW_WIDTH-1:0]   ls;
    logic [LOW_WIDTH-1:0]   low_n;
    logic [D_SIZE-1:0]      s_n;
    logic                   emit;

    // A zero range still shifts by the maximum so the stream keeps moving; the error flag records it.
    always_comb begin
        range_zero = (range_pre == '0);
        d          = range_zero ? D_SIZE'(RANGE_WIDTH - 1) : lz;
        range_n    = range_pre << d;
        ls         = low_pre << d;
        s1         = s_q + d;
        emit       = (s1 >= D_SIZE'(BYTE_THRESH));
        low_n      = emit ? {{BW{1'b0}}, ls[RANGE_WIDTH-1:0]} : ls;
        s_n        = emit ? s1 - D_SIZE'(BYTE_BITS) : s1;
        st_n.range = range_n;
        st_n.low   = low_n;
        st_n.s     = s_n;
    end

    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q           <= coder_reset_state();
            out_valid      <= 1'b0;
            out_byte_valid <= 1'b0;
            out_byte       <= '0;
            out_flush      <= 1'b0;
            out_low        <= '0;
            out_s          <= '0;
            out_range      <= RANGE_INIT;
            err_range_zero <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (in_flush) begin
                // Flush reports the final state and rearms the coder for the next stream.
                st_q           <= coder_reset_state();
                out_flush      <= 1'b1;
                out_byte_valid <= 1'b0;
                out_byte       <= '0;
                out_low        <= low_q;
                out_s          <= s_q;
                out_range      <= range_q;
            end else begin
                st_q           <= st_n;
                out_flush      <= 1'b0;
                out_byte_valid <= emit;
                out_byte       <= emit ? ls[LOW_WIDTH-1:RANGE_WIDTH] : '0;
                out_low        <= low_n;
                out_s          <= s_n;
                out_range      <= range_n;
                if (range_zero) err_range_zero <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_2_pipe.sv
// Scoreboard bench for stage_2_pipe: a bit-accurate coder model queues the expected beat on
// acceptance, and the beat is compared while held and popped when downstream takes it.
module tb_stage_2_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_flush;
    logic [15:0] UU, VV, lut_u, lut_v;
    logic        COMP_mux_1;
    logic        bool;
    logic [3:0]  symbol;
    logic        out_valid;
    logic        out_ready;
    logic        out_byte_valid;
    logic [7:0]  out_byte;
    logic        out_flush;
    logic [23:0] out_low;
    logic [4:0]  out_s;
    logic [15:0] out_range;
    logic        err_range_zero;

    always #5 clk = ~clk;

    stage_2_pipe dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_flush       (in_flush),
        .UU             (UU),
        .VV             (VV),
        .lut_u          (lut_u),
        .lut_v          (lut_v),
        .COMP_mux_1     (COMP_mux_1),
        .bool           (bool),
        .symbol         (symbol),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_byte_valid (out_byte_valid),
        .out_byte       (out_byte),
        .out_flush      (out_flush),
        .out_low        (out_low),
        .out_s          (out_s),
        .out_range      (out_range),
        .err_range_zero (err_range_zero)
    );

    typedef struct {
        logic        fl;
        logic        bv;
        logic [7:0]  by;
        logic [23:0] low;
        logic [4:0]  s;
        logic [15:0] rng;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_range, m_low, m_s;
    logic        m_err, m_ov;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input logic fl, input logic b, input logic sym0,
                                        input logic comp, input logic [31:0] uu,
                                        input logic [31:0] vv, input logic [31:0] lu,
                                        input logic [31:0] lv);
        exp_t e;
        logic [31:0] rr, u, v, vb, rng, low, d, ls, s1;
        if (fl) begin
            e = '{fl: 1'b1, bv: 1'b0, by: 8'h0, low: m_low[23:0], s: m_s[4:0], rng: m_range[15:0]};
            m_range = 32'h8000; m_low = 0; m_s = 0;
            return e;
        end
        rr  = m_range >> 8;
        u   = (((rr * uu) >> 1) + lu) & 32'h1FFFF;
        v   = (((rr * vv) >> 1) + lv) & 32'h1FFFF;
        vb  = (((rr * vv) >> 1) + 4) & 32'h1FFFF;
        low = m_low;
        if (b) begin
            if (sym0) begin
                low = (m_low + m_range - vb) & 32'hFFFFFF;
                rng = vb & 32'hFFFF;
            end else rng = (m_range - vb) & 32'hFFFF;
        end else if (comp) begin
            low = (m_low + m_range - u) & 32'hFFFFFF;
            rng = (u - v) & 32'hFFFF;
        end else rng = (m_range - v) & 32'hFFFF;
        if (rng == 0) begin
            d = 15;
            m_err = 1'b1;
        end else begin
            d = 0;
            while (rng[15 - d] == 1'b0) d++;
        end
        rng = (rng << d) & 32'hFFFF;
        ls  = (low << d) & 32'hFFFFFF;
        s1  = (m_s + d) & 32'h1F;
        e.fl = 1'b0;
        if (s1 >= 9) begin
            e.bv = 1'b1;
            e.by = ls[23:16];
            low  = ls & 32'hFFFF;
            s1   = s1 - 8;
        end else begin
            e.bv = 1'b0;
            e.by = 8'h0;
            low  = ls;
        end
        m_range = rng; m_low = low; m_s = s1;
        e.low = low[23:0]; e.s = s1[4:0]; e.rng = rng[15:0];
        return e;
    endfunction

    // One cycle: drive at the negedge, check the held/consumed beat, update the model.
    task automatic beat(input logic vld, input logic fl, input logic b, input logic [3:0] sym,
                        input logic comp, input logic [15:0] uu, input logic [15:0] vv,
                        input logic [15:0] lu, input logic [15:0] lv, input logic rdy);
        logic acc;
        exp_t e;
        in_valid = vld; in_flush = fl; bool = b; symbol = sym; COMP_mux_1 = comp;
        UU = uu; VV = vv; lut_u = lu; lut_v = lv; out_ready = rdy;
        #1;
        chk("in_ready", in_ready, !m_ov || rdy);
        chk("out_valid", out_valid, m_ov);
        chk("err_range_zero", err_range_zero, m_err);
        if (m_ov && sb.size() > 0) begin
            e = sb[0];
            chk("out_flush", out_flush, e.fl);
            chk("out_byte_valid", out_byte_valid, e.bv);
            chk("out_low", out_low, e.low);
            chk("out_s", out_s, e.s);
            chk("out_range", out_range, e.rng);
            if (e.bv) begin
                chk("out_byte", out_byte, e.by);
                chk("low_top_clear", out_low[23:16], 8'h0);
            end
            if (rdy) void'(sb.pop_front());
        end
        acc = vld && (!m_ov || rdy);
        if (acc) sb.push_back(model_step(fl, b, sym[0], comp, uu, vv, lu, lv));
        m_ov = acc ? 1'b1 : (rdy ? 1'b0 : m_ov);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_range", out_range, 16'h8000);
        chk("rst_out_low", out_low, 24'h0);
        chk("rst_out_s", out_s, 5'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_err", err_range_zero, 1'b0);
        chk("rst_out_flush", out_flush, 1'b0);
        chk("rst_byte_valid", out_byte_valid, 1'b0);
        reset_n = 1'b1;
        m_range = 32'h8000; m_low = 0; m_s = 0; m_err = 1'b0; m_ov = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic chk_now(input string tag, input logic [15:0] rng, input logic [23:0] low,
                           input logic [4:0] s);
        chk({tag, "_range"}, out_range, rng);
        chk({tag, "_low"}, out_low, low);
        chk({tag, "_s"}, out_s, s);
    endtask

    task automatic rand_beat(input logic rdy);
        logic        b, comp, vld;
        logic [15:0] uu, vv, lu, lv;
        vld  = ($urandom_range(0, 9) != 0);
        b    = $urandom_range(0, 1);
        comp = $urandom_range(0, 1);
        lu   = 16'($urandom_range(0, 15));
        lv   = 16'($urandom_range(0, 32'(lu)));
        uu   = 16'($urandom_range(3, 16'h1F0));
        vv   = b ? 16'($urandom_range(1, 16'h1EF)) : 16'($urandom_range(1, 32'(uu) - 2));
        beat(vld, 1'b0, b, 4'($urandom), comp, uu, vv, lu, lv, rdy);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
        UU = 0; VV = 0; lut_u = 0; lut_v = 0; COMP_mux_1 = 0; bool = 0; symbol = 0;
        m_range = 32'h8000; m_low = 0; m_s = 0; m_err = 1'b0; m_ov = 1'b0;
        do_reset();

        // Directed beats from reset with hand-derived results.
        beat(1, 0, 1, 4'h1, 0, 16'h0, 16'h100, 16'h0, 16'h0, 1);
        chk_now("bool_sym1", 16'h8008, 24'h7FF8, 5'd1);
        do_reset();
        beat(1, 0, 1, 4'h0, 0, 16'h0, 16'h100, 16'h0, 16'h0, 1);
        chk_now("bool_sym0", 16'hFFF0, 24'h0, 5'd2);
        do_reset();
        beat(1, 0, 0, 4'h0, 1, 16'h180, 16'h100, 16'd8, 16'd4, 1);
        chk_now("comp1", 16'h8010, 24'h7FE0, 5'd2);
        do_reset();
        beat(1, 0, 0, 4'h0, 0, 16'h180, 16'h100, 16'd8, 16'd4, 1);
        chk_now("comp0", 16'hFFF0, 24'h0, 5'd2);

        // Mid-stream reset drops the pending beat.
        do_reset();

        // Random stream with a 5-cycle downstream stall in the middle.
        for (int i = 0; i < 2000; i++) rand_beat(!(i >= 1000 && i < 1005));
        beat(0, 0, 0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1);
        beat(0, 0, 0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1);
        chk("sb_drained", sb.size(), 0);

        // Flush after three symbols, then the coder restarts from reset state.
        do_reset();
        for (int i = 0; i < 3; i++)
            beat(1, 0, 0, 4'h0, i[0], 16'h180, 16'h100, 16'd8, 16'd4, 1);
        beat(1, 1, 0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1);
        chk("flush_flag", out_flush, 1'b1);
        beat(1, 0, 1, 4'h1, 0, 16'h0, 16'h100, 16'h0, 16'h0, 1);
        chk_now("post_flush", 16'h8008, 24'h7FF8, 5'd1);

        // Zero range sets a sticky error that survives flush and later beats.
        beat(1, 0, 0, 4'h0, 1, 16'h100, 16'h100, 16'd4, 16'd4, 1);
        chk("err_set", err_range_zero, 1'b1);
        beat(1, 1, 0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1);
        beat(1, 0, 1, 4'h0, 0, 16'h0, 16'h100, 16'h0, 16'h0, 1);
        beat(0, 0, 0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1);
        chk("err_sticky", err_range_zero, 1'b1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
